// File: rtl/neuron_step_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : snn_pkg
//  Purpose  : Shared types and arithmetic helpers for the LIF step scheduler.
//             Holds the FSM state encoding, the membrane width, the default
//             firing threshold and the saturating leak / add helpers.
//  Revision : 1.0  initial release
// ============================================================================
package snn_pkg;

    localparam int SNN_W      = 8;
    localparam int SNN_THRESH = 64;
    localparam int STATE_W    = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LEAK  = 3'd1,
        S_INTEG = 3'd2,
        S_FIRE  = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Plain vector constants so the state register stays a logic vector.
    localparam logic [STATE_W-1:0] ST_IDLE  = S_IDLE;
    localparam logic [STATE_W-1:0] ST_LEAK  = S_LEAK;
    localparam logic [STATE_W-1:0] ST_INTEG = S_INTEG;
    localparam logic [STATE_W-1:0] ST_FIRE  = S_FIRE;
    localparam logic [STATE_W-1:0] ST_DONE  = S_DONE;

    localparam logic signed [SNN_W-1:0] SNN_MAX = {1'b0, {(SNN_W-1){1'b1}}};
    localparam logic signed [SNN_W-1:0] SNN_MIN = {1'b1, {(SNN_W-1){1'b0}}};

    // Clamp a W+1 bit intermediate back to W bits.
    function automatic logic signed [SNN_W-1:0] sat_w(input logic signed [SNN_W:0] x);
        logic signed [SNN_W-1:0] r;
        if (x[SNN_W] != x[SNN_W-1]) begin
            r = x[SNN_W] ? SNN_MIN : SNN_MAX;
        end else begin
            r = x[SNN_W-1:0];
        end
        return r;
    endfunction

    // v*0.75 as (v>>>1)+(v>>>2). Arithmetic shifts round toward -inf, so
    // small negative values drift downward (-1 -> -2); this is deliberate.
    function automatic logic signed [SNN_W-1:0] leak(input logic signed [SNN_W-1:0] v);
        logic signed [SNN_W:0] ext;
        logic signed [SNN_W:0] sum;
        ext = {v[SNN_W-1], v};
        sum = (ext >>> 1) + (ext >>> 2);
        return sat_w(sum);
    endfunction

    function automatic logic signed [SNN_W-1:0] sat_add(input logic signed [SNN_W-1:0] a,
                                                        input logic signed [SNN_W-1:0] b);
        logic signed [SNN_W:0] sum;
        sum = {a[SNN_W-1], a} + {b[SNN_W-1], b};
        return sat_w(sum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_step_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_step_scheduler_if
//  Purpose  : Control, weighted-input stream and spike-output bundle of the
//             step scheduler.
//  Ports    : step_start/busy/done   step control
//             in_valid/in_ready/in_idx/in_weight/in_last  input beats
//             spk_valid/spk_idx/spk_vec                    spike outputs
//             master = upstream/downstream side, slave = scheduler
//  Revision : 1.0  initial release
// ============================================================================
interface neuron_step_scheduler_if
    import snn_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3,
    parameter int W         = SNN_W
);
    logic                   step_start;
    logic                   busy;
    logic                   in_valid;
    logic                   in_ready;
    logic [IDX_W-1:0]       in_idx;
    logic signed [W-1:0]    in_weight;
    logic                   in_last;
    logic                   spk_valid;
    logic [IDX_W-1:0]       spk_idx;
    logic [N_NEURONS-1:0]   spk_vec;
    logic                   done;

    modport master (
        output step_start, in_valid, in_idx, in_weight, in_last,
        input  busy, in_ready, spk_valid, spk_idx, spk_vec, done
    );

    modport slave (
        input  step_start, in_valid, in_idx, in_weight, in_last,
        output busy, in_ready, spk_valid, spk_idx, spk_vec, done
    );
endinterface
`default_nettype wire

// File: rtl/neuron_step_scheduler_membrane_update_unit.sv
`default_nettype none
// ============================================================================
//  Module   : membrane_update_unit
//  Purpose  : Combinational single-membrane datapath shared by all neurons.
//             mode selects leak (LEAK), saturating add (INTEG) or threshold
//             compare-and-clear (FIRE); any other mode passes v_in through.
//  Ports    : mode    scheduler state
//             v_in    selected membrane value
//             weight  input beat contribution (INTEG only)
//             v_out   updated membrane value
//             fire    v_in >= THRESH while in FIRE
//  Revision : 1.0  initial release
// ============================================================================
module membrane_update_unit
    import snn_pkg::*;
#(
    parameter int THRESH = SNN_THRESH
) (
    input  logic [STATE_W-1:0]      mode,
    input  logic signed [SNN_W-1:0] v_in,
    input  logic signed [SNN_W-1:0] weight,
    output logic signed [SNN_W-1:0] v_out,
    output logic                    fire
);

    localparam logic signed [SNN_W-1:0] THRESH_W = SNN_W'(THRESH);

    always_comb begin
        v_out = v_in;
        fire  = 1'b0;
        case (mode)
            ST_LEAK:  v_out = leak(v_in);
            ST_INTEG: v_out = sat_add(v_in, weight);
            ST_FIRE: begin
                if (v_in >= THRESH_W) begin
                    fire  = 1'b1;
                    v_out = '0;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/neuron_step_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : neuron_step_scheduler
//  Purpose  : Time-multiplexes one LIF update datapath over N_NEURONS
//             membranes. Per step: leak each neuron, integrate streamed
//             weighted beats, fire/reset neurons at threshold, report spikes.
//  Ports    : clk   rising-edge clock
//             rst   asynchronous active-low reset
//             bus   neuron_step_scheduler_if.slave (control, beats, spikes)
//  Notes    : W must equal snn_pkg::SNN_W; the shared datapath is sized by
//             the package.
//  Revision : 1.0  initial release
// ============================================================================
module neuron_step_scheduler
    import snn_pkg::*;
#(
    parameter int N_NEURONS = 8,
    parameter int IDX_W     = 3,
    parameter int W         = SNN_W,
    parameter int THRESH    = SNN_THRESH
) (
    input  logic                     clk,
    input  logic                     rst,
    neuron_step_scheduler_if.slave   bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    logic [STATE_W-1:0]     state_q,     state_d;
    logic [IDX_W-1:0]       cnt_q,       cnt_d;
    logic signed [W-1:0]    v_q [N_NEURONS];
    logic signed [W-1:0]    v_d [N_NEURONS];
    logic [N_NEURONS-1:0]   acc_q,       acc_d;
    logic [N_NEURONS-1:0]   spk_vec_q,   spk_vec_d;
    logic                   spk_valid_q, spk_valid_d;
    logic [IDX_W-1:0]       spk_idx_q,   spk_idx_d;

    logic                   w_beat;
    logic                   w_wr;
    logic                   w_cnt_last;
    logic [IDX_W-1:0]       w_sel_idx;
    logic signed [W-1:0]    w_v_sel;
    logic signed [W-1:0]    w_v_new;
    logic                   w_fire;

    assign w_beat     = bus.in_valid && (state_q == ST_INTEG);
    assign w_cnt_last = (cnt_q == LAST_IDX);
    // Beats address the bank by in_idx; the leak and fire sweeps by counter.
    assign w_sel_idx  = (state_q == ST_INTEG) ? bus.in_idx : cnt_q;
    assign w_wr       = (state_q == ST_LEAK) || (state_q == ST_FIRE) || w_beat;

    // Indices past N_NEURONS match no entry: the read yields 0 and the write
    // below hits nothing, which is how out-of-range beats get dropped.
    always_comb begin
        w_v_sel = '0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (w_sel_idx == IDX_W'(i)) begin
                w_v_sel = v_q[i];
            end
        end
    end

    membrane_update_unit #(
        .THRESH (THRESH)
    ) u_mem_unit (
        .mode   (state_q),
        .v_in   (w_v_sel),
        .weight (bus.in_weight),
        .v_out  (w_v_new),
        .fire   (w_fire)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        spk_vec_d   = spk_vec_q;
        spk_valid_d = 1'b0;
        spk_idx_d   = spk_idx_q;
        v_d         = v_q;

        for (int i = 0; i < N_NEURONS; i++) begin
            if (w_wr && (w_sel_idx == IDX_W'(i))) begin
                v_d[i] = w_v_new;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.step_start) begin
                    state_d = ST_LEAK;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            ST_LEAK: begin
                if (w_cnt_last) begin
                    state_d = ST_INTEG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_INTEG: begin
                if (w_beat && bus.in_last) begin
                    state_d = ST_FIRE;
                    cnt_d   = '0;
                end
            end
            ST_FIRE: begin
                if (w_fire) begin
                    acc_d       = acc_q | (N_NEURONS'(1) << cnt_q);
                    spk_valid_d = 1'b1;
                    spk_idx_d   = cnt_q;
                end
                if (w_cnt_last) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                spk_vec_d = acc_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            spk_vec_q   <= '0;
            spk_valid_q <= 1'b0;
            spk_idx_q   <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            spk_vec_q   <= spk_vec_d;
            spk_valid_q <= spk_valid_d;
            spk_idx_q   <= spk_idx_d;
            v_q         <= v_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.in_ready  = (state_q == ST_INTEG);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.spk_valid = spk_valid_q;
    assign bus.spk_idx   = spk_idx_q;
    assign bus.spk_vec   = spk_vec_q;

endmodule
`default_nettype wire

// File: doc/neuron_step_scheduler.md
Name: neuron_step_scheduler

Overview:
- Time-multiplexes one leaky-integrate-and-fire update datapath across N_NEURONS membrane potentials held in an internal register bank.
- Runs a fixed per-timestep sequence:
  - leak every neuron;
  - integrate the streamed weighted synaptic inputs;
  - fire and reset neurons at or above threshold;
  - report the spike vector.
- Sits between the synapse/weight fetch logic (upstream) and the next layer's spike input (downstream).

Parameters:
- N_NEURONS, 8, number of neurons sequenced; must be ≤ 2**IDX_W.
- IDX_W, 3, neuron index width.
- W, 8, signed membrane/weight width.
- THRESH, 64, signed firing threshold (W bits).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- step_start  in  1  request one timestep; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- in_valid  in  1  weighted input beat valid.
- in_ready  out  1  high only in INTEG.
- in_idx  in  IDX_W  target neuron of the beat.
- in_weight  in  W  signed contribution.
- in_last  in  1  marks the final beat of the timestep.
- spk_valid  out  1  one-cycle pulse per firing neuron.
- spk_idx  out  IDX_W  index of the firing neuron.
- spk_vec  out  N_NEURONS  spike vector of the last completed step.
- done  out  1  one-cycle pulse at end of step.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all membranes=0, scan counter=0.
  - busy=0, in_ready=0, spk_valid=0, spk_idx=0, spk_vec=0, done=0.
  - Takes effect mid-step too; the partial step is discarded and no done pulse is produced.
- States: IDLE -> LEAK -> INTEG -> FIRE -> DONE -> IDLE.
- IDLE:
  - step_start=1 -> LEAK next cycle, counter=0.
  - step_start outside IDLE is ignored; requests are not queued.
- LEAK (exactly N_NEURONS cycles, neuron i in cycle i):
  - v[i] <= (v[i]>>>1) + (v[i]>>>2), using arithmetic shifts, computed in W+1 bits, then saturated to W.
  - Negative values drift: -1 -> -2 and -4 -> -3. This is intended; the behaviour matches the existing datapath.
  - After the last neuron -> INTEG.
- INTEG:
  - in_ready=1. A beat is accepted when in_valid & in_ready.
  - Accepted beat: v[in_idx] <= sat(v[in_idx] + in_weight), saturating to [-2**(W-1), 2**(W-1)-1].
  - Multiple beats to the same neuron accumulate, one beat per cycle, with no hazards.
  - in_idx ≥ N_NEURONS: beat is accepted and dropped.
  - Beat accepted with in_last=1: the beat is applied, then -> FIRE; in_ready=0 from the next cycle.
  - in_last without in_valid has no effect.
- FIRE (exactly N_NEURONS cycles, neuron i in cycle i):
  - If v[i] ≥ THRESH (signed compare): v[i] <= 0, set spike bit i, and next cycle spk_valid=1 with spk_idx=i.
  - Otherwise v[i] is unchanged.
  - Spike outputs are registered (1-cycle latency) with no backpressure.
- DONE (1 cycle):
  - done=1, spk_vec <= accumulated spike bits, then -> IDLE.
  - The spk_valid for neuron N-1 coincides with the DONE cycle.
- Minimum step length, with one input beat: N + 1 + N + 1 cycles (18 for N=8).
- spk_vec holds its value until the next DONE or reset.

Decomposition:
- Shared package snn_pkg holds:
  - state enum (IDLE, LEAK, INTEG, FIRE, DONE);
  - W;
  - leak function (shift-sum with saturation);
  - saturating signed add function;
  - THRESH default.
- One sub-module, membrane_update_unit: combinational leak/add/compare on a single membrane value. It is selected by the FSM mode, and the scheduler instantiates it once.

Test Plan:
- Reset mid-INTEG with v[2]=50 -> busy=0, no done pulse. A new step with a single beat (idx 2, +0, last) ends with spk_vec=0, and v[2] reads back as 0 (leak of 0).
- v[0]=64, then a step with beat (0,+0,last) -> leak gives 48, no spike, spk_vec=0. Next step with beat (0,+20,last) -> 36+20=56, no spike.
- v[3]=0, step with beats (3,+70),(3,+10,last) -> v=80 ≥ 64, so spk_valid with spk_idx=3, spk_vec=8'b0000_1000, and v[3]=0 afterwards.
- Saturation:
  - v[1]=100, beats (1,+100,last) -> leak 75, add gives 127 (clamped), spike.
  - v[4]=-128, beat (4,-100,last) -> -96-100 clamps to -128.
- Negative drift: v[5]=-1, beat (5,0,last) -> v[5]=-2, no spike.
- in_valid held low in INTEG for 5 cycles -> FSM stays in INTEG; step_start pulsed while busy is ignored. A beat with in_idx=7 and N_NEURONS=6 is dropped. done rises exactly once per step.
